// File: rtl/board_editor.sv
// Board editing front end: overlays cursor-driven edits (row load, cell toggle,
// row clear, clear-all sweep) onto the live board before it reaches the engine.
module board_editor #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 0,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 select,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_center,
  input  logic [1:0]           mode,
  input  logic [COLS-1:0]      row_data,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic [ROWS*COLS-1:0] board_out,
  output logic [RW-1:0]        cursor_row,
  output logic [CW-1:0]        cursor_col,
  output logic                 busy,
  output logic                 edit_pulse
);

  localparam int N  = ROWS * COLS;
  localparam int BW = $clog2(N);

  typedef enum logic {IDLE, SWEEP} state_t;
  typedef enum logic [1:0] {ROW_LOAD, CELL_TOGGLE, ROW_CLEAR, CLEAR_ALL} mode_t;

  state_t          state, state_n;
  logic [RW-1:0]   sweep_cnt, cnt_n;
  logic [4:0]      btn_now, btn_q, press;
  logic [N-1:0]    board_n;
  logic [RW-1:0]   row_n, row_dec, row_inc;
  logic [CW-1:0]   col_n, col_dec, col_inc;
  logic            busy_n, pulse_n;
  logic [BW-1:0]   cur_base, cur_bit, sweep_base;
  logic            press_up, press_down, press_left, press_right, press_center;

  // Button history runs every cycle so a button held across a select rise never fires.
  assign btn_now      = {btn_center, btn_right, btn_left, btn_down, btn_up};
  assign press        = btn_now & ~btn_q;
  assign press_up     = press[0];
  assign press_down   = press[1];
  assign press_left   = press[2];
  assign press_right  = press[3];
  assign press_center = press[4];

  assign cur_base   = BW'(cursor_row * COLS);
  assign cur_bit    = cur_base + BW'(cursor_col);
  assign sweep_base = BW'(sweep_cnt * COLS);

  always_comb begin
    row_dec = cursor_row - RW'(1);
    row_inc = cursor_row + RW'(1);
    col_dec = cursor_col - CW'(1);
    col_inc = cursor_col + CW'(1);
    if (cursor_row == '0)               row_dec = (WRAP != 0) ? RW'(ROWS - 1) : cursor_row;
    if (cursor_row == RW'(ROWS - 1))    row_inc = (WRAP != 0) ? '0 : cursor_row;
    if (cursor_col == '0)               col_dec = (WRAP != 0) ? CW'(COLS - 1) : cursor_col;
    if (cursor_col == CW'(COLS - 1))    col_inc = (WRAP != 0) ? '0 : cursor_col;
  end

  // Edits are applied at the pre-move cursor; moves are resolved in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = sweep_cnt;
    board_n = board_out;
    row_n   = cursor_row;
    col_n   = cursor_col;
    busy_n  = busy;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (select) begin
          board_n = board_in;
          if (press_center) begin
            case (mode_t'(mode))
              ROW_LOAD: begin
                board_n[cur_base +: COLS] = row_data;
                pulse_n = 1'b1;
              end
              CELL_TOGGLE: begin
                board_n[cur_bit] = ~board_in[cur_bit];
                pulse_n = 1'b1;
              end
              ROW_CLEAR: begin
                board_n[cur_base +: COLS] = '0;
                pulse_n = 1'b1;
              end
              CLEAR_ALL: begin
                state_n = SWEEP;
                cnt_n   = '0;
                busy_n  = 1'b1;
              end
              default: ;
            endcase
          end
          if (press_up && !press_down)        row_n = row_dec;
          else if (press_down && !press_up)   row_n = row_inc;
          if (press_left && !press_right)     col_n = col_dec;
          else if (press_right && !press_left) col_n = col_inc;
        end
      end
      SWEEP: begin
        board_n[sweep_base +: COLS] = '0;
        if (sweep_cnt == RW'(ROWS - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          pulse_n = 1'b1;
        end else begin
          cnt_n = sweep_cnt + RW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      btn_q      <= '0;
      board_out  <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      busy       <= 1'b0;
      edit_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      sweep_cnt  <= cnt_n;
      btn_q      <= btn_now;
      board_out  <= board_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      busy       <= busy_n;
      edit_pulse <= pulse_n;
    end
  end

endmodule

// File: tb/tb_board_editor.sv
// Self-checking bench for board_editor: a saturating and a wrapping instance share
// stimulus and are compared against a cell-array reference model.
module tb_board_editor;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic select, btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [1:0] mode;
  logic [COLS-1:0] row_data;
  logic [N-1:0] board_in;
  logic [N-1:0] bo [2];
  logic [3:0] cr [2];
  logic [3:0] cc [2];
  logic bz [2];
  logic ep [2];

  board_editor #(.ROWS(ROWS), .COLS(COLS), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .select(select),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .mode(mode), .row_data(row_data), .board_in(board_in),
    .board_out(bo[0]), .cursor_row(cr[0]), .cursor_col(cc[0]),
    .busy(bz[0]), .edit_pulse(ep[0]));

  board_editor #(.ROWS(ROWS), .COLS(COLS), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .select(select),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .mode(mode), .row_data(row_data), .board_in(board_in),
    .board_out(bo[1]), .cursor_row(cr[1]), .cursor_col(cc[1]),
    .busy(bz[1]), .edit_pulse(ep[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] ones;

  // Reference model: board as a cell grid, cursors as plain integers.
  bit mc [2][ROWS][COLS];
  int mrow [2];
  int mcol [2];
  bit mbusy, mpulse, msweep;
  int mk;
  bit mprev [5];

  function automatic logic [N-1:0] model_board(input int i);
    logic [N-1:0] v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = mc[i][r][c];
    return v;
  endfunction

  function automatic int step_pos(input int pos, input int maxv, input bit dec, input bit inc, input bit wrap);
    if (dec && !inc) return (pos == 0) ? (wrap ? maxv : 0) : pos - 1;
    if (inc && !dec) return (pos == maxv) ? (wrap ? 0 : maxv) : pos + 1;
    return pos;
  endfunction

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] v;
    for (int w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mc[i][r][c] = 0;
      mrow[i] = 0;
      mcol[i] = 0;
    end
    mbusy = 0; mpulse = 0; msweep = 0; mk = 0;
    for (int b = 0; b < 5; b++) mprev[b] = 0;
  endtask

  task automatic model_update();
    bit pu, pd, pl, pr, pc;
    if (reset) begin
      model_reset();
      return;
    end
    pu = btn_up && !mprev[0];
    pd = btn_down && !mprev[1];
    pl = btn_left && !mprev[2];
    pr = btn_right && !mprev[3];
    pc = btn_center && !mprev[4];
    mpulse = 0;
    if (msweep) begin
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < COLS; c++) mc[i][mk][c] = 0;
      if (mk == ROWS - 1) begin
        msweep = 0; mbusy = 0; mpulse = 1;
      end else begin
        mk++;
      end
    end else if (select) begin
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) mc[i][r][c] = board_in[r*COLS+c];
        if (pc) begin
          case (mode)
            2'd0: for (int c = 0; c < COLS; c++) mc[i][mrow[i]][c] = row_data[c];
            2'd1: mc[i][mrow[i]][mcol[i]] = !mc[i][mrow[i]][mcol[i]];
            2'd2: for (int c = 0; c < COLS; c++) mc[i][mrow[i]][c] = 0;
            default: ;
          endcase
        end
        mrow[i] = step_pos(mrow[i], ROWS - 1, pu, pd, i == 1);
        mcol[i] = step_pos(mcol[i], COLS - 1, pl, pr, i == 1);
      end
      if (pc && mode != 2'd3) mpulse = 1;
      if (pc && mode == 2'd3) begin
        msweep = 1; mk = 0; mbusy = 1;
      end
    end
    mprev[0] = btn_up; mprev[1] = btn_down; mprev[2] = btn_left;
    mprev[3] = btn_right; mprev[4] = btn_center;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_center, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic tap(input int which);
    set_btns(5'(1 << which));
    step();
    set_btns(5'b0);
    step();
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    select = 1'b0; mode = 2'd0; row_data = '0; board_in = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_btns(5'b0);
    select = 1'b1; mode = 2'd0; row_data = '1; board_in = rand_board();
    #2 reset = 1'b1;
    model_reset();
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bo[i] !== '0 || cr[i] !== 4'd0 || cc[i] !== 4'd0 || bz[i] !== 1'b0 || ep[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_state dut%0d: got board=%h row=%0d col=%0d busy=%b pulse=%b, expected all zero",
                 i, bo[i], cr[i], cc[i], bz[i], ep[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_row_load();
    logic [N-1:0] exp;
    do_reset();
    select = 1'b1; board_in = '0; mode = 2'd0; row_data = 16'hA5A5;
    for (int k = 0; k < 3; k++) tap(1);
    set_btns(5'b10000);
    step();
    exp = '0;
    exp[48 +: 16] = 16'hA5A5;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cr[i] !== 4'd3 || bo[i] !== exp || ep[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL row_load dut%0d: got row=%0d board=%h pulse=%b, expected row=3 board=%h pulse=1",
                 i, cr[i], bo[i], ep[i], exp);
      end
    end
    set_btns(5'b0);
    step();
    checks++;
    if (ep[0] !== 1'b0 || bo[0] !== '0) begin
      failures++;
      $display("[TB] FAIL row_load_after: got pulse=%b board=%h, expected pulse=0 board=0", ep[0], bo[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    select = 1'b1; board_in = '0;
    tap(0);
    tap(2);
    checks++;
    if (cr[0] !== 4'd0 || cc[0] !== 4'd0) begin
      failures++;
      $display("[TB] FAIL saturate_low: got (%0d,%0d), expected (0,0)", cr[0], cc[0]);
    end
    checks++;
    if (cr[1] !== 4'd15 || cc[1] !== 4'd15) begin
      failures++;
      $display("[TB] FAIL wrap_low: got (%0d,%0d), expected (15,15)", cr[1], cc[1]);
    end
    tap(1);
    tap(3);
    checks++;
    if (cr[0] !== 4'd1 || cc[0] !== 4'd1 || cr[1] !== 4'd0 || cc[1] !== 4'd0) begin
      failures++;
      $display("[TB] FAIL wrap_high: got sat=(%0d,%0d) wrap=(%0d,%0d), expected sat=(1,1) wrap=(0,0)",
               cr[0], cc[0], cr[1], cc[1]);
    end
  endtask

  task automatic test_toggle();
    logic [N-1:0] exp;
    int pulses;
    do_reset();
    select = 1'b1; board_in = ones; mode = 2'd1;
    tap(1); tap(1);
    for (int k = 0; k < 5; k++) tap(3);
    pulses = 0;
    set_btns(5'b10000);
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      exp = ones;
      if (cyc == 0) exp[37] = 1'b0;
      if (ep[0] === 1'b1) pulses++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bo[i] !== exp) begin
          failures++;
          $display("[TB] FAIL toggle cyc%0d dut%0d: got %h expected %h", cyc, i, bo[i], exp);
        end
      end
    end
    set_btns(5'b0);
    step();
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL toggle_held_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_clear_all();
    logic [N-1:0] exp, bin;
    do_reset();
    select = 1'b1; board_in = ones; mode = 2'd3;
    step();
    set_btns(5'b10000);
    step();
    checks++;
    if (bz[0] !== 1'b1 || bo[0] !== ones || ep[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_start: got busy=%b pulse=%b board=%h, expected busy=1 pulse=0 all ones",
               bz[0], ep[0], bo[0]);
    end
    for (int k = 0; k < ROWS; k++) begin
      select = 1'($urandom);
      board_in = rand_board();
      mode = 2'($urandom);
      set_btns(5'($urandom));
      step();
      exp = ones;
      for (int r = 0; r <= k; r++) exp[r*COLS +: COLS] = '0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bo[i] !== exp || bz[i] !== (k < ROWS - 1) || ep[i] !== (k == ROWS - 1)
            || cr[i] !== 4'd0 || cc[i] !== 4'd0) begin
          failures++;
          $display("[TB] FAIL sweep k=%0d dut%0d: got board=%h busy=%b pulse=%b cur=(%0d,%0d), expected board=%h busy=%b pulse=%b cur=(0,0)",
                   k, i, bo[i], bz[i], ep[i], cr[i], cc[i], exp, k < ROWS - 1, k == ROWS - 1);
        end
      end
    end
    bin = rand_board();
    select = 1'b1; board_in = bin; mode = 2'd0;
    set_btns(5'b0);
    step();
    checks++;
    if (bo[0] !== bin || bz[0] !== 1'b0 || ep[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_reload: got board=%h busy=%b pulse=%b, expected board=%h busy=0 pulse=0",
               bo[0], bz[0], ep[0], bin);
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp;
    do_reset();
    select = 1'b1; board_in = ones; mode = 2'd2;
    for (int k = 0; k < 4; k++) tap(1);
    set_btns(5'b00011);
    step();
    checks++;
    if (cr[0] !== 4'd4 || cr[1] !== 4'd4) begin
      failures++;
      $display("[TB] FAIL up_down_cancel: got %0d/%0d expected 4", cr[0], cr[1]);
    end
    set_btns(5'b0);
    step();
    set_btns(5'b11000);
    step();
    exp = ones;
    exp[64 +: 16] = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bo[i] !== exp || cr[i] !== 4'd4 || cc[i] !== 4'd1 || ep[i] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL edit_and_move dut%0d: got board=%h cur=(%0d,%0d) pulse=%b, expected board=%h cur=(4,1) pulse=1",
                 i, bo[i], cr[i], cc[i], ep[i], exp);
      end
    end
    set_btns(5'b0);
    step();
  endtask

  task automatic test_reset_mid_sweep();
    logic [N-1:0] bin;
    do_reset();
    select = 1'b1; board_in = ones; mode = 2'd3;
    tap(1);
    set_btns(5'b10000);
    step();
    set_btns(5'b0);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bo[i] !== '0 || cr[i] !== 4'd0 || bz[i] !== 1'b0 || ep[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abort_sweep dut%0d: got board=%h row=%0d busy=%b pulse=%b, expected zeros",
                 i, bo[i], cr[i], bz[i], ep[i]);
      end
    end
    step();
    reset = 1'b0;
    bin = rand_board();
    board_in = bin; mode = 2'd0;
    step();
    checks++;
    if (bo[0] !== bin || bz[0] !== 1'b0 || ep[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_abort: got board=%h busy=%b pulse=%b, expected board=%h busy=0 pulse=0",
               bo[0], bz[0], ep[0], bin);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      select = ($urandom_range(0, 9) != 0);
      btn_up = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 2) == 0);
      btn_left = ($urandom_range(0, 2) == 0);
      btn_right = ($urandom_range(0, 2) == 0);
      btn_center = ($urandom_range(0, 3) == 0);
      mode = 2'($urandom);
      row_data = 16'($urandom);
      board_in = rand_board();
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bo[i] !== model_board(i)) begin
          failures++;
          $display("[TB] FAIL rand_board cyc%0d dut%0d: got %h expected %h", cyc, i, bo[i], model_board(i));
        end
        checks++;
        if (cr[i] !== 4'(mrow[i]) || cc[i] !== 4'(mcol[i])) begin
          failures++;
          $display("[TB] FAIL rand_cursor cyc%0d dut%0d: got (%0d,%0d) expected (%0d,%0d)",
                   cyc, i, cr[i], cc[i], mrow[i], mcol[i]);
        end
        checks++;
        if (bz[i] !== mbusy || ep[i] !== mpulse) begin
          failures++;
          $display("[TB] FAIL rand_flags cyc%0d dut%0d: got busy=%b pulse=%b expected busy=%b pulse=%b",
                   cyc, i, bz[i], ep[i], mbusy, mpulse);
        end
      end
    end
  endtask

  initial begin
    ones = '1;
    test_reset();
    test_row_load();
    test_wrap();
    test_toggle();
    test_clear_all();
    test_simultaneous();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
